fp_to_int: RTL and testbench

Sequential IEEE-754 single-precision to signed 32-bit integer converter. It decodes the packed `{sign, exp[7:0], mant[22:0]}` words produced by `fp_adder` back into two's-complement integers, rounding to nearest-even. The block sits behind the adder on the result path and uses a valid/ready handshake on both sides. Alignment uses a 1-bit-per-cycle iterative shifter, so latency depends on the data.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_unpack.sv | 33 +++
 rtl/fp_to_int.sv | 200 ++++++++++++++++++++
 tb/tb_fp_to_int.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point package: IEEE-754 single field widths, special
// integer results and the converter state encoding.
package fp_pkg;

   localparam int BIAS    = 32'sd127;
   localparam int EXP_INF = 32'sd255;
   localparam int MANT_W  = 32'sd23;
   localparam int EXP_W   = 32'sd8;

   localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single unpacker: splits the packed word into its
// fields and classifies it. Shared with the adder datapath.
module fp_unpack
   import fp_pkg::*;
#(
   parameter int BIAS = 32'sd127
) (
   input  logic                    a_word,
   input  logic [30:0]             a_rest,
   output logic                    sign,
   output logic [MANT_W-1:0]       mant,
   output logic                    is_nan,
   output logic                    is_inf,
   output logic                    is_zero_or_denorm,
   output logic signed [9:0]       exp_unb
);

   logic [EXP_W-1:0] exp_s;
   logic             mant_nz_s;

   assign sign      = a_word;
   assign exp_s     = a_rest[MANT_W +: EXP_W];
   assign mant      = a_rest[MANT_W-1:0];
   assign mant_nz_s = (mant != {MANT_W{1'b0}});

   assign is_nan            = (exp_s == EXP_W'(EXP_INF)) &&  mant_nz_s;
   assign is_inf            = (exp_s == EXP_W'(EXP_INF)) && !mant_nz_s;
   assign is_zero_or_denorm = (exp_s == {EXP_W{1'b0}});

   // Exponent widened before removing the bias so negative values survive.
   assign exp_unb = signed'({2'b00, exp_s} - 10'(BIAS));

endmodule

// File: rtl/fp_to_int.sv
// Sequential IEEE-754 single to signed 32-bit integer converter with
// round-to-nearest-even. Alignment is done one bit per cycle, so latency
// depends on the exponent. Valid/ready handshake on both sides.
module fp_to_int
   import fp_pkg::*;
#(
   parameter int BIAS       = 32'sd127,
   parameter int MAX_RSHIFT = 32'sd24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Result,
   output logic        overflow,
   output logic        invalid,
   output logic        inexact
);

   // Exponent thresholds: integer weight of the hidden bit, smallest
   // exponent still worth shifting, and the first saturating exponent.
   localparam logic signed [9:0] E_MANT = 10'(MANT_W);
   localparam logic signed [9:0] E_MIN  = 10'(MANT_W - MAX_RSHIFT);
   localparam logic signed [9:0] E_SAT  = 10'sd31;

   logic                    sign_s;
   logic [MANT_W-1:0]       mant_s;
   logic                    is_nan_s;
   logic                    is_inf_s;
   logic                    is_zod_s;
   logic signed [9:0]       exp_unb_s;

   logic                    left_s;
   logic [4:0]              count_s;
   logic                    round_up_s;
   logic [31:0]             mag_s;
   logic [31:0]             signed_res_s;

   state_t                  state_r;
   logic                    in_ready_r;
   logic                    out_valid_r;
   logic [31:0]             result_r;
   logic                    overflow_r;
   logic                    invalid_r;
   logic                    inexact_r;
   logic [31:0]             work_r;
   logic                    guard_r;
   logic                    sticky_r;
   logic [4:0]              count_r;
   logic                    left_r;
   logic                    sign_r;

   fp_unpack #(
      .BIAS              (BIAS)
   ) u_unpack (
      .a_word            (A[31]),
      .a_rest            (A[30:0]),
      .sign              (sign_s),
      .mant              (mant_s),
      .is_nan            (is_nan_s),
      .is_inf            (is_inf_s),
      .is_zero_or_denorm (is_zod_s),
      .exp_unb           (exp_unb_s)
   );

   // Shift direction and distance needed to align the hidden bit to bit 0 weight.
   always_comb begin
      left_s  = 1'b0;
      count_s = 5'd0;
      if (exp_unb_s >= E_MANT) begin
         left_s  = 1'b1;
         count_s = 5'(exp_unb_s - E_MANT);
      end else begin
         left_s  = 1'b0;
         count_s = 5'(E_MANT - exp_unb_s);
      end
   end

   // Nearest-even rounding of the aligned magnitude, then sign application.
   assign round_up_s   = guard_r & (sticky_r | work_r[0]);
   assign mag_s        = work_r + {31'd0, round_up_s};
   assign signed_res_s = sign_r ? (32'd0 - mag_s) : mag_s;

   // Converter FSM: decode/classify, iterative align, round, hold result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         result_r    <= 32'd0;
         overflow_r  <= 1'b0;
         invalid_r   <= 1'b0;
         inexact_r   <= 1'b0;
         work_r      <= 32'd0;
         guard_r     <= 1'b0;
         sticky_r    <= 1'b0;
         count_r     <= 5'd0;
         left_r      <= 1'b0;
         sign_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  sign_r <= sign_s;
                  if (is_nan_s) begin
                     result_r    <= INT_MIN;
                     invalid_r   <= 1'b1;
                     state_r     <= ST_DONE;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else if (is_inf_s) begin
                     result_r    <= sign_s ? INT_MIN : INT_MAX;
                     invalid_r   <= 1'b1;
                     state_r     <= ST_DONE;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else if (is_zod_s) begin
                     result_r    <= 32'd0;
                     inexact_r   <= (mant_s != {MANT_W{1'b0}});
                     state_r     <= ST_DONE;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else if (exp_unb_s < E_MIN) begin
                     // Magnitude below one half always rounds to zero.
                     result_r    <= 32'd0;
                     inexact_r   <= 1'b1;
                     state_r     <= ST_DONE;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else if (exp_unb_s >= E_SAT) begin
                     // -2^31 is the one representable value in this range.
                     if (sign_s && (exp_unb_s == E_SAT) && (mant_s == {MANT_W{1'b0}})) begin
                        result_r <= INT_MIN;
                     end else begin
                        result_r   <= sign_s ? INT_MIN : INT_MAX;
                        overflow_r <= 1'b1;
                     end
                     state_r     <= ST_DONE;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else begin
                     work_r     <= {8'd0, 1'b1, mant_s};
                     guard_r    <= 1'b0;
                     sticky_r   <= 1'b0;
                     count_r    <= count_s;
                     left_r     <= left_s;
                     in_ready_r <= 1'b0;
                     state_r    <= (count_s != 5'd0) ? ST_SHIFT : ST_ROUND;
                  end
               end
            end
            ST_SHIFT: begin
               if (left_r) begin
                  work_r <= {work_r[30:0], 1'b0};
               end else begin
                  work_r   <= {1'b0, work_r[31:1]};
                  sticky_r <= sticky_r | guard_r;
                  guard_r  <= work_r[0];
               end
               count_r <= count_r - 5'd1;
               if (count_r == 5'd1) begin
                  state_r <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               result_r    <= signed_res_s;
               inexact_r   <= guard_r | sticky_r;
               state_r     <= ST_DONE;
               out_valid_r <= 1'b1;
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r     <= ST_IDLE;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
                  overflow_r  <= 1'b0;
                  invalid_r   <= 1'b0;
                  inexact_r   <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign Result    = result_r;
   assign overflow  = overflow_r;
   assign invalid   = invalid_r;
   assign inexact   = inexact_r;

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: directed cases with hand-computed
// expectations, then random operands checked against an arithmetic model.
module tb_fp_to_int;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Result;
   logic        overflow;
   logic        invalid;
   logic        inexact;

   int n_checks = 0;
   int n_errors = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   fp_to_int dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .overflow  (overflow),
      .invalid   (invalid),
      .inexact   (inexact)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Reference: value = 1.mant * 2^E computed with integer arithmetic,
   // nearest-even by quotient/remainder; latency from the shift distance.
   function automatic void model(input logic [31:0] a, output logic [31:0] r,
                                 output logic ov, output logic inv, output logic inx,
                                 output int lat);
      int     e;
      int     ue;
      int     s;
      longint full;
      longint q;
      longint dv;
      longint rem;
      e   = int'(a[30:23]);
      r   = 32'd0;
      ov  = 1'b0;
      inv = 1'b0;
      inx = 1'b0;
      lat = 1;
      if (e == 255) begin
         inv = 1'b1;
         if (a[22:0] != 23'd0) r = 32'h8000_0000;
         else r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else if (e == 0) begin
         inx = (a[22:0] != 23'd0);
      end else begin
         ue   = e - 127;
         full = longint'(a[22:0]) + 64'sd8388608;
         if (ue < -1) begin
            inx = 1'b1;
         end else if (ue >= 31) begin
            if (a[31] && ue == 31 && a[22:0] == 23'd0) begin
               r = 32'h8000_0000;
            end else begin
               r  = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
               ov = 1'b1;
            end
         end else begin
            if (ue >= 23) begin
               q   = full * (64'sd1 << (ue - 23));
               lat = ue - 23 + 2;
            end else begin
               s   = 23 - ue;
               dv  = 64'sd1 << s;
               q   = full / dv;
               rem = full % dv;
               inx = (rem != 64'sd0);
               if (rem * 2 > dv || (rem * 2 == dv && (q % 2) == 1)) q = q + 1;
               lat = s + 2;
            end
            r = a[31] ? 32'(64'sd0 - q) : 32'(q);
         end
      end
   endfunction

   // One transaction: offer, measure latency, check, optionally stall, drain.
   task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] er,
                          input logic eov, input logic einv, input logic einx,
                          input int elat, input int hold);
      int lat;
      @(negedge clk);
      check({name, ":in_ready"}, {31'd0, in_ready}, 32'd1);
      A        = a;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({name, ":latency"}, 32'(lat), 32'(elat));
      check({name, ":result"}, Result, er);
      check({name, ":flags"}, {29'd0, overflow, invalid, inexact}, {29'd0, eov, einv, einx});
      for (int i = 0; i < hold; i++) begin
         A        = ~a;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         check({name, ":hold_state"}, {30'd0, out_valid, in_ready}, 32'd2);
         check({name, ":hold_result"}, Result, er);
         check({name, ":hold_flags"}, {29'd0, overflow, invalid, inexact}, {29'd0, eov, einv, einx});
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, ":drained"}, {28'd0, out_valid, overflow, invalid, inexact}, 32'd0);
      check({name, ":ready_again"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] er;
      logic        eov;
      logic        einv;
      logic        einx;
      int          elat;
      int          sel;
      logic [7:0]  ex;
      logic [22:0] mn;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_handshake", {30'd0, in_ready, out_valid}, 32'd2);
      check("reset_result", Result, 32'd0);
      check("reset_flags", {29'd0, overflow, invalid, inexact}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases: name, operand, result, ov, inv, inx, latency, stall.
      run_one("one_point_five", 32'h3FC0_0000, 32'd2,          1'b0, 1'b0, 1'b1, 25, 0);
      run_one("tie_even_2p5",   32'h4020_0000, 32'd2,          1'b0, 1'b0, 1'b1, 24, 0);
      run_one("neg_three",      32'hC040_0000, 32'hFFFF_FFFD,  1'b0, 1'b0, 1'b0, 24, 5);
      run_one("two_pow_24",     32'h4B80_0000, 32'h0100_0000,  1'b0, 1'b0, 1'b0, 3,  0);
      run_one("pos_sat",        32'h4F00_0000, 32'h7FFF_FFFF,  1'b1, 1'b0, 1'b0, 1,  0);
      run_one("int_min_exact",  32'hCF00_0000, 32'h8000_0000,  1'b0, 1'b0, 1'b0, 1,  0);
      run_one("nan",            32'h7FC0_0000, 32'h8000_0000,  1'b0, 1'b1, 1'b0, 1,  0);
      run_one("point_four",     32'h3ECC_CCCD, 32'd0,          1'b0, 1'b0, 1'b1, 1,  0);
      run_one("half_to_zero",   32'h3F00_0000, 32'd0,          1'b0, 1'b0, 1'b1, 26, 0);
      run_one("e23_no_shift",   32'h4B00_0001, 32'h0080_0001,  1'b0, 1'b0, 1'b0, 2,  0);
      run_one("neg_inf",        32'hFF80_0000, 32'h8000_0000,  1'b0, 1'b1, 1'b0, 1,  2);
      run_one("denorm",         32'h0000_0001, 32'd0,          1'b0, 1'b0, 1'b1, 1,  0);
      run_one("neg_e30_max",    32'hCEFF_FFFF, 32'h8000_0080,  1'b0, 1'b0, 1'b0, 9,  0);

      // Reset in the middle of an alignment drops the operand.
      @(negedge clk);
      A        = 32'h3FC0_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_shift_busy", {30'd0, in_ready, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_shift_rst_handshake", {30'd0, in_ready, out_valid}, 32'd2);
      check("mid_shift_rst_result", Result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_one("after_reset", 32'h4140_0000, 32'd12, 1'b0, 1'b0, 1'b0, 22, 0);

      // Random operands, biased toward the interesting exponent range.
      for (int n = 0; n < 200; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      ex = 8'd0;
         else if (sel == 1) ex = 8'd255;
         else if (sel == 2) ex = 8'($urandom_range(150, 165));
         else               ex = 8'($urandom_range(124, 158));
         mn = 23'($urandom());
         if ($urandom_range(0, 3) == 0) mn = mn & 23'h7F_0000;
         if ($urandom_range(0, 7) == 0) mn = 23'd0;
         a = {1'($urandom()), ex, mn};
         model(a, er, eov, einv, einx, elat);
         run_one("random", a, er, eov, einv, einx, elat, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
